// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int   c_data_bits = 8;
    localparam logic c_line_idle = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync
//  Description : Flop-chain synchroniser for the asynchronous serial line.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic rx,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Reset to the idle level so a reset never looks like a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{c_line_idle}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with one-cycle data and framing-error strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DIV_WIDTH-1:0]   clock_div,
    input  logic                   rx,
    output logic [c_data_bits-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   rx_error,
    output logic                   rx_busy
);

    localparam int c_idx_w = $clog2(c_data_bits);

    logic                   w_rx_s;
    logic                   w_half_end;
    logic                   w_full_end;

    rx_state_e              r_state;
    logic [DIV_WIDTH-1:0]   r_div;
    logic [DIV_WIDTH:0]     r_cnt;
    logic [c_idx_w-1:0]     r_idx;
    logic [c_data_bits-1:0] r_shift;
    logic [c_data_bits-1:0] r_data;
    logic                   r_valid;
    logic                   r_error;
    logic                   r_busy;

    uart_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .rx    (rx),
        .rx_s  (w_rx_s)
    );

    // One extra counter bit lets the full period 2*(div+1) fit for any divider.
    assign w_half_end = (r_cnt == {1'b0, r_div});
    assign w_full_end = (r_cnt == {r_div, 1'b1});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_error <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rx_s == 1'b0) begin
                        r_div   <= clock_div;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_half_end) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        if (w_rx_s == 1'b0) begin
                            r_state <= ST_DATA;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_full_end) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rx_s;
                        if (r_idx == c_idx_w'(c_data_bits - 1)) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop-bit lets a zero-gap next start be caught.
                    if (w_full_end) begin
                        r_cnt  <= '0;
                        r_busy <= 1'b0;
                        if (w_rx_s == 1'b1) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= ST_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (w_rx_s == 1'b1) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data  = r_data;
    assign rx_valid = r_valid;
    assign rx_error = r_error;
    assign rx_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] clock_div = 16'd3;
    logic        rx = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_error;
    logic        rx_busy;

    int n_vec = 0;
    int n_err = 0;

    int v_cnt = 0;
    int e_cnt = 0;
    int both_cnt = 0;
    int wide_cnt = 0;
    int busy_cycles = 0;
    logic prev_v = 1'b0;
    logic prev_e = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_rx #(
        .SYNC_STAGES (2),
        .DIV_WIDTH   (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .clock_div (clock_div),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_error  (rx_error),
        .rx_busy   (rx_busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rx_valid === 1'b1) begin
            got_q.push_back(rx_data);
            v_cnt++;
        end
        if (rx_error === 1'b1) e_cnt++;
        if (rx_valid === 1'b1 && rx_error === 1'b1) both_cnt++;
        if ((rx_valid === 1'b1 && prev_v) || (rx_error === 1'b1 && prev_e)) wide_cnt++;
        if (rx_busy === 1'b1) busy_cycles++;
        prev_v = (rx_valid === 1'b1);
        prev_e = (rx_error === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        v_cnt       = 0;
        e_cnt       = 0;
        busy_cycles = 0;
    endtask

    // Drives the first nbits of {stop, data, start}, LSB first.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int nbits, input int div);
        logic [9:0] f;
        f = {stop_b, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = f[i];
            tick(2 * (div + 1));
        end
    endtask

    task automatic check_queue(input string tag);
        check({tag, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s byte%0d", tag, i),
                  (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hDEAD, {24'd0, exp_q[i]});
        end
    endtask

    initial begin
        logic [7:0] b;

        // Reset state
        tick(4);
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_valid", rx_valid, 1'b0);
        check("reset rx_error", rx_error, 1'b0);
        check("reset rx_busy", rx_busy, 1'b0);
        reset = 1'b0;
        tick(4);

        // Single frame 0xA5 at an 8-clock bit period
        clear_mon();
        send_frame(8'hA5, 1'b1, 10, 3);
        tick(8);
        check("A5 valid count", v_cnt, 1);
        check("A5 rx_data", rx_data, 8'hA5);
        check("A5 error count", e_cnt, 0);
        check("A5 busy after", rx_busy, 1'b0);
        check("A5 busy cycles", busy_cycles, 76);

        // Three-clock glitch is rejected at the start-bit sample
        clear_mon();
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(20);
        check("glitch valid", v_cnt, 0);
        check("glitch error", e_cnt, 0);
        check("glitch busy", rx_busy, 1'b0);
        check("glitch busy cycles", busy_cycles, 4);

        // Framing error followed by a held-low line, then a good frame
        clear_mon();
        send_frame(8'h3C, 1'b0, 10, 3);
        tick(30);
        rx = 1'b1;
        tick(16);
        check("break error count", e_cnt, 1);
        check("break valid count", v_cnt, 0);
        check("break rx_data kept", rx_data, 8'hA5);
        send_frame(8'h81, 1'b1, 10, 3);
        tick(8);
        check("after break valid", v_cnt, 1);
        check("after break data", rx_data, 8'h81);
        check("after break errors", e_cnt, 1);

        // Divider changed mid-frame must not disturb the frame
        clear_mon();
        fork
            send_frame(8'h96, 1'b1, 10, 3);
            begin
                tick(20);
                clock_div = 16'd9;
            end
        join
        clock_div = 16'd3;
        tick(8);
        check("div change valid", v_cnt, 1);
        check("div change data", rx_data, 8'h96);

        // Back-to-back frames, minimum divider
        clear_mon();
        exp_q.delete();
        clock_div = 16'd0;
        tick(2);
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
        send_frame(8'h00, 1'b1, 10, 0);
        send_frame(8'hFF, 1'b1, 10, 0);
        send_frame(8'h55, 1'b1, 10, 0);
        tick(10);
        check_queue("b2b div0");
        check("b2b div0 errors", e_cnt, 0);

        // Back-to-back frames, divider 7
        clear_mon();
        clock_div = 16'd7;
        tick(2);
        send_frame(8'h00, 1'b1, 10, 7);
        send_frame(8'hFF, 1'b1, 10, 7);
        send_frame(8'h55, 1'b1, 10, 7);
        tick(20);
        check_queue("b2b div7");
        check("b2b div7 errors", e_cnt, 0);

        // Reset during data bit 4 of 0x0F
        clear_mon();
        clock_div = 16'd3;
        tick(2);
        send_frame(8'h0F, 1'b1, 5, 3);
        rx = 1'b0;
        tick(4);
        reset = 1'b1;
        rx = 1'b1;
        tick(1);
        check("midreset rx_data", rx_data, 8'h00);
        check("midreset rx_valid", rx_valid, 1'b0);
        check("midreset rx_error", rx_error, 1'b0);
        check("midreset rx_busy", rx_busy, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(10);
        check("midreset no valid", v_cnt, 0);
        check("midreset no error", e_cnt, 0);
        send_frame(8'hC3, 1'b1, 10, 3);
        tick(8);
        check("post reset valid", v_cnt, 1);
        check("post reset data", rx_data, 8'hC3);

        // Loopback of 256 random bytes at divider 5
        clear_mon();
        exp_q.delete();
        clock_div = 16'd5;
        tick(2);
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1, 10, 5);
        end
        tick(20);
        check_queue("loopback");
        check("loopback errors", e_cnt, 0);

        check("strobe overlap", both_cnt, 0);
        check("strobe width", wide_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, the receive-side counterpart of the team's UART transmitter.
- Uses the same `clock_div` semantics, so one bit period is 2*(clock_div+1) master clocks.
- Samples the asynchronous `rx` line in the single master-clock domain. No derived clocks.
- Delivers each byte as a one-cycle strobe, with framing-error reporting.
- Sits between the board serial pin and the byte consumer, for example a command parser.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `rx` (minimum 2).
- DIV_WIDTH, 16, width of `clock_div`.

Ports:
- clock  in  1  master clock.
- reset  in  1  synchronous, active-high reset.
- clock_div  in  DIV_WIDTH  half-bit period minus 1, in clocks.
- rx  in  1  asynchronous serial input; idle high.
- rx_data  out  8  last correctly received byte.
- rx_valid  out  1  one-cycle strobe: `rx_data` has just been updated.
- rx_error  out  1  one-cycle strobe: framing error (stop bit sampled low).
- rx_busy  out  1  high while a frame is in progress (states START/DATA/STOP).

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high, named `clock` and `reset`.
  - Reset values: rx_data=0x00, rx_valid=0, rx_error=0, rx_busy=0, state=IDLE.
  - Synchroniser flops reset to 1, the idle line level.
- Synchroniser: `rx` passes through SYNC_STAGES flops giving `rx_s`. Every latency figure below is measured from `rx_s`.
- Divider latch:
  - `clock_div` is latched into `div_q` on start detection.
  - Changes to `clock_div` mid-frame have no effect.
- Counters:
  - Bit-timer `cnt` is DIV_WIDTH+1 bits wide.
  - Half period H = div_q+1. Full period F = 2*(div_q+1). No overflow for any `clock_div`.
- State machine (IDLE, START, DATA, STOP, BREAK):
  - IDLE: when `rx_s`=0, latch `div_q`, set cnt=0, go to START.
  - START: when cnt == H-1, sample `rx_s`.
    - If 0: cnt=0, bit index=0, go to DATA.
    - If 1: false start (glitch); go to IDLE with no strobe.
  - DATA: when cnt == F-1, sample `rx_s` into shift register bit [index] (LSB first) and set cnt=0.
    - Leave for STOP after index 7.
  - STOP: when cnt == F-1, sample `rx_s`.
    - If 1: rx_data <= shift register, pulse rx_valid next cycle, go to IDLE.
    - If 0: pulse rx_error, leave rx_data unchanged, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. This prevents a held-low line from being read as repeated frames.
- Timing:
  - Sampling points fall at mid-bit.
  - IDLE is re-entered at mid-stop-bit, so back-to-back frames with no idle gap are received.
  - Latency: rx_valid rises 1 clock after the stop-bit sample point.
- Strobes:
  - rx_valid and rx_error are each exactly one cycle wide and are never high together.
  - There is no backpressure. The consumer must capture `rx_data` on the strobe.
  - `rx_data` stays stable until the next valid frame.
- Reset mid-frame: returns to IDLE immediately and discards the partial byte. No strobes occur on or after the reset cycle.
- clock_div=0: bit period is 2 clocks, H=1. This case must work.

Decomposition:
- `uart_pkg`: rx state enum, data width constant 8, idle line level constant.
- Sub-module `uart_sync`: parameterised SYNC_STAGES flop chain with synchronous reset to 1.
- Shift register, counter and FSM remain in `uart_rx`.

Test Plan:
- clock_div=3 (bit period 8 clocks). Drive 0xA5 as start 0, bits 1,0,1,0,0,1,0,1, stop 1 → one rx_valid pulse, rx_data=0xA5, rx_error never high, rx_busy low after the stop sample.
- clock_div=3. Pull rx low for 3 clocks, then high → no rx_valid, no rx_error; `uart_rx` returns to IDLE after the START sample.
- clock_div=3. Frame 0x3C with stop bit 0, held low 30 clocks, then high → a single rx_error pulse, rx_data keeps its previous value, no second frame decoded, next valid frame 0x81 → rx_valid with rx_data=0x81.
- clock_div=0, then clock_div=7. Back-to-back 0x00, 0xFF, 0x55 with no idle gap → three rx_valid pulses with the values in order.
- clock_div=3. Assert reset at data bit 4 of 0x0F, release, send 0xC3 → no strobe for 0x0F; rx_valid with 0xC3; all outputs zero during reset.
- Loopback from the team's UART transmitter at the same clock_div=5. Send 256 random bytes → every byte received in order, zero errors.
